// File: rtl/recip_engine.sv
// Reciprocal engine: reads a 16-bit divisor from byte memory and writes back
// floor(0x8000 / D) big-endian. D = 0 saturates the result to 0xFFFF.
module recip_engine #(
   parameter int ADDR_W       = 8,
   parameter int OPERAND_ADDR = 8,
   parameter int RESULT_ADDR  = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata
);

   // state  | meaning
   // IDLE   | wait for armed Start falling edge
   // RD_HI  | present divisor high-byte address
   // RD_LO  | present low-byte address, capture high byte
   // CAP    | capture low byte, choose divide or saturate
   // DIV    | 16 restoring-division iterations
   // WR_HI  | write result high byte
   // WR_LO  | write result low byte
   // DONE   | Ack high until Start is seen high
   typedef enum logic [2:0] {
      S_IDLE, S_RD_HI, S_RD_LO, S_CAP, S_DIV, S_WR_HI, S_WR_LO, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] OP_HI  = ADDR_W'(OPERAND_ADDR);
   localparam logic [ADDR_W-1:0] OP_LO  = ADDR_W'(OPERAND_ADDR + 1);
   localparam logic [ADDR_W-1:0] RES_HI = ADDR_W'(RESULT_ADDR);
   localparam logic [ADDR_W-1:0] RES_LO = ADDR_W'(RESULT_ADDR + 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_armed;
   logic        r_ack;
   logic [15:0] r_d;
   logic [15:0] r_rem;
   logic [15:0] r_q;
   logic [3:0]  r_cnt;

   logic [15:0] w_d_cap;
   logic        w_num_bit;
   logic [16:0] w_trial;
   logic        w_ge;
   logic [15:0] w_diff;

   assign w_d_cap   = {r_d[15:8], mem_rdata};
   // Numerator 0x8000 contributes a single 1 on the first iteration only.
   assign w_num_bit = (r_cnt == 4'd15);
   assign w_trial   = {r_rem, w_num_bit};
   assign w_ge      = (w_trial >= {1'b0, r_d});
   // Only used when w_ge, where the true difference is below D and fits 16 bits.
   assign w_diff    = w_trial[15:0] - r_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_armed <= 1'b0;
         r_ack   <= 1'b0;
         r_d     <= 16'd0;
         r_rem   <= 16'd0;
         r_q     <= 16'd0;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (Start)
                  r_armed <= 1'b1;
               else if (r_armed)
                  r_armed <= 1'b0;
            end
            S_RD_LO: r_d[15:8] <= mem_rdata;
            S_CAP: begin
               r_d[7:0] <= mem_rdata;
               r_rem    <= 16'd0;
               r_cnt    <= 4'd15;
               r_q      <= (w_d_cap == 16'd0) ? 16'hFFFF : 16'd0;
            end
            S_DIV: begin
               r_rem <= w_ge ? w_diff : w_trial[15:0];
               r_q   <= {r_q[14:0], w_ge};
               r_cnt <= r_cnt - 4'd1;
            end
            S_WR_LO: r_ack <= 1'b1;
            S_DONE: begin
               if (Start) begin
                  r_ack   <= 1'b0;
                  r_armed <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wdata   = 8'd0;
      case (r_state)
         S_IDLE:  if (r_armed && !Start) w_state_nxt = S_RD_HI;
         S_RD_HI: begin
            mem_addr    = OP_HI;
            mem_rd_en   = 1'b1;
            w_state_nxt = S_RD_LO;
         end
         S_RD_LO: begin
            mem_addr    = OP_LO;
            mem_rd_en   = 1'b1;
            w_state_nxt = S_CAP;
         end
         S_CAP:   w_state_nxt = (w_d_cap == 16'd0) ? S_WR_HI : S_DIV;
         S_DIV:   if (r_cnt == 4'd0) w_state_nxt = S_WR_HI;
         S_WR_HI: begin
            mem_addr    = RES_HI;
            mem_wdata   = r_q[15:8];
            mem_wr_en   = 1'b1;
            w_state_nxt = S_WR_LO;
         end
         S_WR_LO: begin
            mem_addr    = RES_LO;
            mem_wdata   = r_q[7:0];
            mem_wr_en   = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE:  if (Start) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign Ack = r_ack;

endmodule

// File: tb/tb_recip_engine.sv
// Bench for recip_engine: byte memory model, table of divisors with a result
// scoreboard, plus reset-mid-job, Start-toggle and back-to-back sequences.
module tb_recip_engine;

   logic       clk;
   logic       rst;
   logic       start;
   logic       ack;
   logic [7:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rdata;
   logic       mem_wr_en;
   logic [7:0] mem_wdata;

   logic [7:0] mem [0:255];
   logic       ld_en;
   logic [7:0] ld_addr;
   logic [7:0] ld_data;

   int pass_cnt;
   int chk_cnt;
   logic [15:0] sb_q [$];

   typedef struct {
      logic [15:0] d;
      logic [15:0] r;
      int          cyc;
   } vec_t;

   recip_engine #(.ADDR_W(8), .OPERAND_ADDR(8), .RESULT_ADDR(10)) dut (
      .Clk      (clk),
      .Reset    (rst),
      .Start    (start),
      .Ack      (ack),
      .mem_addr (mem_addr),
      .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (ld_en) mem[ld_addr] <= ld_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic setup(input logic [15:0] d);
      poke(8'd8, d[15:8]);
      poke(8'd9, d[7:0]);
      poke(8'd10, 8'h5A);
      poke(8'd11, 8'hC3);
   endtask

   // Start high for two sampled edges, then low; returns right after edge 0.
   task automatic launch();
      logic was_ack;
      @(negedge clk);
      was_ack = ack;
      start = 1'b1;
      @(negedge clk);
      if (was_ack) check("ack_drop", {31'd0, ack}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
   endtask

   task automatic run_job(input logic [15:0] d, input logic [15:0] r, input int cyc, input bit toggle);
      int ack_cyc;
      int wr_cyc;
      bit overlap;
      logic [15:0] exp_r;
      ack_cyc = -1; wr_cyc = -1; overlap = 1'b0;
      setup(d);
      sb_q.push_back(r);
      launch();
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (mem_rd_en && mem_wr_en) overlap = 1'b1;
         if (mem_wr_en && wr_cyc < 0) wr_cyc = k;
         if (toggle && k == 6) start = 1'b1;
         if (toggle && k == 9) start = 1'b0;
         if (ack) begin
            ack_cyc = k;
            break;
         end
      end
      if (ack_cyc < 0) $display("FAIL ack_timeout: D=0x%04h no Ack within 60 cycles", d);
      check($sformatf("ack_cycle D=%04h", d), ack_cyc, cyc);
      check($sformatf("wr_cycle D=%04h", d), wr_cyc, cyc - 2);
      check($sformatf("strobe_excl D=%04h", d), {31'd0, overlap}, 32'd0);
      exp_r = sb_q.pop_front();
      check($sformatf("result D=%04h", d), {16'd0, mem[10], mem[11]}, {16'd0, exp_r});
   endtask

   vec_t vecs [8];

   initial begin
      pass_cnt = 0; chk_cnt = 0;
      rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
      vecs[0] = '{d: 16'h0004, r: 16'h2000, cyc: 22};
      vecs[1] = '{d: 16'h0024, r: 16'h038E, cyc: 22};
      vecs[2] = '{d: 16'h0001, r: 16'h8000, cyc: 22};
      vecs[3] = '{d: 16'hFFFF, r: 16'h0000, cyc: 22};
      vecs[4] = '{d: 16'h0000, r: 16'hFFFF, cyc: 6};
      vecs[5] = '{d: 16'h00FF, r: 16'h0080, cyc: 22};
      vecs[6] = '{d: 16'h8000, r: 16'h0001, cyc: 22};
      vecs[7] = '{d: 16'h8001, r: 16'h0000, cyc: 22};

      repeat (2) @(negedge clk);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("rst_addr", {24'd0, mem_addr}, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_job(vecs[i].d, vecs[i].r, vecs[i].cyc, 1'b0);

      run_job(16'h0024, 16'h038E, 22, 1'b1);

      // Reset in cycle 10 of a job, inside the division.
      setup(16'h1234);
      launch();
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ack", {31'd0, ack}, 32'd0);
      check("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("midrst_idle_ack", {31'd0, ack}, 32'd0);
      check("midrst_bytes", {16'd0, mem[10], mem[11]}, 32'h00005AC3);
      run_job(16'h0003, 16'h2AAA, 22, 1'b0);

      // Back-to-back: next job launched straight out of DONE.
      run_job(16'h0004, 16'h2000, 22, 1'b0);
      run_job(16'h0100, 16'h0080, 22, 1'b0);

      if (sb_q.size() != 0) check("sb_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
